// File: rtl/multi_nco_accumulator.sv
`default_nettype none
// ============================================================================
//  Module   : multi_nco_accumulator
//  Purpose  : NCH independent phase accumulators (NCO core). Each channel has
//             its own frequency increment and phase offset. Both are double
//             buffered (shadow/active), so one strobe retunes every channel
//             coherently. Outputs are the registered, truncated phase and a
//             one-cycle wrap pulse per channel.
//  Revision : 1.0 - initial release
// ============================================================================
module multi_nco_accumulator #(
    parameter int ACC_W = 24,
    parameter int OUT_W = 8,
    parameter int NCH   = 4,
    parameter int CH_AW = 2
) (
    input  logic                   clk,
    input  logic                   clr,
    input  logic                   en,
    input  logic                   wr_en,
    input  logic                   wr_sel,
    input  logic [CH_AW-1:0]       wr_ch,
    input  logic [ACC_W-1:0]       wr_data,
    input  logic                   upd,
    input  logic                   sync,
    output logic [NCH*OUT_W-1:0]   phase,
    output logic [NCH-1:0]         wrap
);

    localparam int c_SHIFT = ACC_W - OUT_W;

    generate
        for (genvar i = 0; i < NCH; i++) begin : g_ch
            logic [ACC_W-1:0] r_acc;
            logic [ACC_W-1:0] r_finc_sh;
            logic [ACC_W-1:0] r_poff_sh;
            logic [ACC_W-1:0] r_finc_act;
            logic [ACC_W-1:0] r_poff_act;
            logic [OUT_W-1:0] r_phase;
            logic             r_wrap;
            logic             w_hit;
            logic [ACC_W-1:0] w_ph_sum;

            // Channel addresses at or above NCH match no generated channel,
            // so such writes simply fall on the floor.
            assign w_hit    = wr_en && (wr_ch == CH_AW'(i));
            // Offset is added modulo 2^ACC_W before truncation to the MSBs.
            assign w_ph_sum = r_acc + r_poff_act;

            // Shadow writes and commit to active registers; upd copies the
            // pre-write shadow because both are non-blocking on the same edge.
            always_ff @(posedge clk) begin
                if (clr) begin
                    r_finc_sh  <= '0;
                    r_poff_sh  <= '0;
                    r_finc_act <= '0;
                    r_poff_act <= '0;
                end else begin
                    if (w_hit && !wr_sel) r_finc_sh <= wr_data;
                    if (w_hit &&  wr_sel) r_poff_sh <= wr_data;
                    if (upd) begin
                        r_finc_act <= r_finc_sh;
                        r_poff_act <= r_poff_sh;
                    end
                end
            end

            // Accumulator with carry-out captured as the wrap pulse; sync wins.
            always_ff @(posedge clk) begin
                if (clr) begin
                    r_acc  <= '0;
                    r_wrap <= 1'b0;
                end else if (sync) begin
                    r_acc  <= '0;
                    r_wrap <= 1'b0;
                end else if (en) begin
                    {r_wrap, r_acc} <= {1'b0, r_acc} + {1'b0, r_finc_act};
                end else begin
                    r_wrap <= 1'b0;
                end
            end

            // Output phase is sampled from the pre-edge accumulator every edge.
            always_ff @(posedge clk) begin
                if (clr) begin
                    r_phase <= '0;
                end else begin
                    r_phase <= OUT_W'(w_ph_sum >> c_SHIFT);
                end
            end

            assign phase[i*OUT_W +: OUT_W] = r_phase;
            assign wrap[i]                 = r_wrap;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_multi_nco_accumulator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multi_nco_accumulator
//  Purpose  : Directed-vector bench for multi_nco_accumulator configured with
//             ACC_W=12, OUT_W=8, NCH=3, CH_AW=2 (phase = acc+poff bits 11:4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_multi_nco_accumulator;

    localparam int ACC_W = 12;
    localparam int OUT_W = 8;
    localparam int NCH   = 3;
    localparam int CH_AW = 2;

    logic                 clk;
    logic                 clr;
    logic                 en;
    logic                 wr_en;
    logic                 wr_sel;
    logic [CH_AW-1:0]     wr_ch;
    logic [ACC_W-1:0]     wr_data;
    logic                 upd;
    logic                 sync;
    logic [NCH*OUT_W-1:0] phase;
    logic [NCH-1:0]       wrap;

    typedef struct {
        bit                   chk;
        logic [NCH*OUT_W-1:0] ph;
        logic [NCH-1:0]       wr;
        string                nm;
    } exp_t;

    exp_t sbq[$];
    exp_t m_e;
    int   n_cmp = 0;
    int   n_err = 0;

    logic [7:0] b_ph [0:13];

    multi_nco_accumulator #(
        .ACC_W (ACC_W),
        .OUT_W (OUT_W),
        .NCH   (NCH),
        .CH_AW (CH_AW)
    ) dut (
        .clk     (clk),
        .clr     (clr),
        .en      (en),
        .wr_en   (wr_en),
        .wr_sel  (wr_sel),
        .wr_ch   (wr_ch),
        .wr_data (wr_data),
        .upd     (upd),
        .sync    (sync),
        .phase   (phase),
        .wrap    (wrap)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [23:0] ph3(input logic [7:0] p0, input logic [7:0] p1,
                                        input logic [7:0] p2);
        return {p2, p1, p0};
    endfunction

    // Queue the outputs expected after the coming edge, then take the edge.
    task automatic tick(input bit chk, input logic [23:0] eph, input logic [2:0] ewr,
                        input string nm);
        exp_t e;
        e.chk = chk;
        e.ph  = eph;
        e.wr  = ewr;
        e.nm  = nm;
        sbq.push_back(e);
        @(posedge clk);
        #2;
        wr_en = 1'b0;
        upd   = 1'b0;
        sync  = 1'b0;
        clr   = 1'b0;
    endtask

    task automatic setwr(input logic sel, input logic [CH_AW-1:0] ch,
                         input logic [ACC_W-1:0] d);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_ch   = ch;
        wr_data = d;
    endtask

    // Monitor: one expectation is consumed per edge, sampled 1 time unit later.
    always @(posedge clk) begin
        #1;
        if (sbq.size() > 0) begin
            m_e = sbq.pop_front();
            if (m_e.chk) begin
                n_cmp++;
                if (phase !== m_e.ph || wrap !== m_e.wr) begin
                    n_err++;
                    $display("FAIL %s: phase=%h wrap=%b, required phase=%h wrap=%b",
                             m_e.nm, phase, wrap, m_e.ph, m_e.wr);
                end
            end
        end
    end

    initial begin
        b_ph = '{8'h00, 8'h03, 8'h06, 8'h09, 8'h0C, 8'h0F, 8'h12,
                 8'h17, 8'h1C, 8'h21, 8'h26, 8'h2B, 8'h30, 8'h37};
        en = 0; wr_en = 0; wr_sel = 0; wr_ch = '0; wr_data = '0;
        upd = 0; sync = 0; clr = 1;
        tick(1, 24'h0, 3'b000, "reset");

        // Single channel counting: step 0x200 wraps every 8 edges.
        setwr(0, 2'd0, 12'h200); tick(1, 24'h0, 3'b000, "cfgA");
        upd = 1;                 tick(1, 24'h0, 3'b000, "cfgA_upd");
        en = 1;
        for (int k = 1; k <= 17; k++)
            tick(1, ph3(8'((k - 1) * 32), 8'h00, 8'h00),
                 (k % 8 == 0) ? 3'b001 : 3'b000, "count");
        en = 0;
        for (int k = 0; k < 10; k++)
            tick(1, ph3(8'h20, 8'h00, 8'h00), 3'b000, "hold");

        // Shadow double buffering on channel 1.
        clr = 1; tick(1, 24'h0, 3'b000, "clrB");
        setwr(0, 2'd1, 12'h030); tick(1, 24'h0, 3'b000, "cfgB");
        upd = 1;                 tick(1, 24'h0, 3'b000, "cfgB_upd");
        en = 1;
        for (int k = 0; k < 14; k++) begin
            if (k == 3)  setwr(0, 2'd1, 12'h050);
            if (k == 5)  upd = 1;
            if (k == 8)  begin setwr(0, 2'd1, 12'h070); upd = 1; end
            if (k == 11) upd = 1;
            tick(1, ph3(8'h00, b_ph[k], 8'h00), 3'b000, "shadow");
        end
        en = 0;

        // Phase offset and full-scale increment carry behaviour.
        clr = 1; tick(1, 24'h0, 3'b000, "clrC");
        setwr(1, 2'd0, 12'h800); tick(1, 24'h0, 3'b000, "poff_pre");
        upd = 1;                 tick(1, 24'h0, 3'b000, "poff_upd_edge");
        tick(1, ph3(8'h80, 8'h00, 8'h00), 3'b000, "poff_after");
        setwr(0, 2'd0, 12'h001); tick(1, ph3(8'h80, 8'h00, 8'h00), 3'b000, "cfgC1");
        upd = 1;                 tick(1, ph3(8'h80, 8'h00, 8'h00), 3'b000, "cfgC2");
        setwr(0, 2'd0, 12'hFFF); tick(1, ph3(8'h80, 8'h00, 8'h00), 3'b000, "cfgC3");
        en = 1; upd = 1;         tick(1, ph3(8'h80, 8'h00, 8'h00), 3'b000, "step1");
        tick(1, ph3(8'h80, 8'h00, 8'h00), 3'b001, "carry_to0");
        tick(1, ph3(8'h80, 8'h00, 8'h00), 3'b000, "to_fff");
        tick(1, ph3(8'h7F, 8'h00, 8'h00), 3'b001, "carry_fff");
        en = 0;
        tick(1, ph3(8'h7F, 8'h00, 8'h00), 3'b000, "en_off");

        // Three channels, sync alignment, then freeze.
        clr = 1; tick(1, 24'h0, 3'b000, "clrD");
        setwr(0, 2'd0, 12'h100); tick(1, 24'h0, 3'b000, "cfgD");
        setwr(0, 2'd1, 12'h200); tick(1, 24'h0, 3'b000, "cfgD");
        setwr(0, 2'd2, 12'h300); tick(1, 24'h0, 3'b000, "cfgD");
        setwr(1, 2'd2, 12'h550); tick(1, 24'h0, 3'b000, "cfgD");
        upd = 1;                 tick(1, 24'h0, 3'b000, "cfgD_upd");
        en = 1;
        for (int k = 1; k <= 5; k++)
            tick(1, ph3(8'((k - 1) * 16), 8'((k - 1) * 32), 8'((k - 1) * 48 + 85)),
                 3'b000, "multi");
        sync = 1; tick(1, ph3(8'h50, 8'hA0, 8'h45), 3'b000, "sync_edge");
        tick(1, ph3(8'h00, 8'h00, 8'h55), 3'b000, "after_sync");
        en = 0;
        for (int k = 0; k < 10; k++)
            tick(1, ph3(8'h10, 8'h20, 8'h85), 3'b000, "frozen");

        // Mid-run clear with a concurrent write that must be lost.
        en = 1;  tick(1, ph3(8'h10, 8'h20, 8'h85), 3'b000, "resume");
        clr = 1; setwr(0, 2'd0, 12'h123); tick(1, 24'h0, 3'b000, "midclr");
        for (int k = 0; k < 3; k++) tick(1, 24'h0, 3'b000, "post_clr");
        upd = 1;
        for (int k = 0; k < 4; k++) tick(1, 24'h0, 3'b000, "post_clr_upd");
        en = 0;

        // Out-of-range channel write is ignored.
        clr = 1; tick(1, 24'h0, 3'b000, "clrF");
        setwr(0, 2'd3, 12'h100); tick(1, 24'h0, 3'b000, "wr_ch3");
        upd = 1;                 tick(1, 24'h0, 3'b000, "upd_ch3");
        en = 1;
        for (int k = 0; k < 4; k++) tick(1, 24'h0, 3'b000, "ch3_ignored");
        setwr(0, 2'd0, 12'h100); tick(1, 24'h0, 3'b000, "ch0_wr");
        upd = 1;                 tick(1, 24'h0, 3'b000, "ch0_upd");
        tick(1, 24'h0, 3'b000, "ch0_step1");
        tick(1, ph3(8'h10, 8'h00, 8'h00), 3'b000, "ch0_step2");
        en = 0;

        @(posedge clk);
        #3;
        n_cmp++;
        if (sbq.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, required 0", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
